// File: rtl/imem_loader.sv
// imem_loader: streams a little-endian byte image into instruction memory and
// holds the core in reset until it is complete. Define IMEM_LOADER_CHECKSUM_EN for the XOR checksum byte.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_FLUSH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [7:0]        hdr_lo_q, hdr_lo_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   words_q, words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        accept;
    logic        all_written;
    logic [15:0] header_n;
    state_t      after_payload;

    assign accept      = byte_valid && byte_ready;
    assign all_written = (words_q == n_q);
    assign header_n    = {byte_data, hdr_lo_q};

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign after_payload = S_CHECK;
`else
    assign after_payload = S_FLUSH;
`endif

    // In LOAD, ready drops once the final word strobe is showing so no extra byte is taken.
    always_comb begin
        byte_ready = 1'b0;
        case (state_q)
            S_HEADER: byte_ready = 1'b1;
            S_LOAD:   byte_ready = !all_written;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK:  byte_ready = 1'b1;
`endif
            default:  byte_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        hdr_lo_d    = hdr_lo_q;
        word_d      = word_q;
        n_d         = n_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        words_d     = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        // Address advances the cycle after each strobe, except after the last word.
        if (mem_we_q && !all_written) begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_start) begin
                    state_d    = S_HEADER;
                    lane_d     = 2'd0;
                    words_d    = '0;
                    mem_addr_d = '0;
                    n_d        = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            S_HEADER: begin
                if (accept) begin
                    if (lane_q == 2'd0) begin
                        hdr_lo_d = byte_data;
                        lane_d   = 2'd1;
                    end else begin
                        lane_d = 2'd0;
                        if (header_n == 16'd0) begin
                            state_d = after_payload;
                        end else if (header_n > 16'(DEPTH)) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_LOAD;
                            n_d     = header_n[ADDR_W:0];
                        end
                    end
                end
            end
            S_LOAD: begin
                if (all_written) begin
                    state_d = after_payload;
                end else if (accept) begin
                    lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    case (lane_q)
                        2'd0: word_d[7:0]   = byte_data;
                        2'd1: word_d[15:8]  = byte_data;
                        2'd2: word_d[23:16] = byte_data;
                        default: begin
                            mem_wdata_d = {byte_data, word_q};
                            mem_we_d    = 1'b1;
                            words_d     = words_q + (ADDR_W+1)'(1);
                        end
                    endcase
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_d = (byte_data == csum_q) ? S_FLUSH : S_ERROR;
                end
            end
`endif
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lane_q      <= 2'd0;
            hdr_lo_q    <= 8'h00;
            word_q      <= 24'h0;
            n_q         <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            words_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            hdr_lo_q    <= hdr_lo_d;
            word_q      <= word_d;
            n_q         <= n_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            words_q     <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign words_written = words_q;
    assign load_done     = (state_q == S_DONE);
    assign load_err      = (state_q == S_ERROR);
    assign cpu_hold      = (state_q != S_DONE);
    assign load_busy     = (state_q == S_HEADER) || (state_q == S_LOAD) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                           (state_q == S_CHECK) ||
`endif
                           (state_q == S_FLUSH);

endmodule
